// File: rtl/iter_alu_exec_element.sv
// Integer execution element: single-cycle ALU ops plus iterative signed MULT/DIV.
// Latency: single-cycle ops complete 1 cycle after start; MULT/DIV complete WIDTH+1 cycles after start.
// Backpressure: none; start is honoured only while idle and is dropped (not queued) while busy.
//
// Ports: clk, reset (sync, active-high); start with inst_num/imm/shamt/rs/rt from the dispatcher;
// busy, completed pulse, out, div_by_zero, illegal_op to writeback. WIDTH >= 8, IMM_WIDTH < WIDTH.
module iter_alu_exec_element #(
    parameter int  WIDTH     = 32,
    parameter int  IMM_WIDTH = 16,
    localparam int SHW       = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [5:0]           inst_num,
    input  logic [IMM_WIDTH-1:0] imm,
    input  logic [SHW-1:0]       shamt,
    input  logic [WIDTH-1:0]     rs,
    input  logic [WIDTH-1:0]     rt,
    output logic                 busy,
    output logic                 completed,
    output logic [WIDTH-1:0]     out,
    output logic                 div_by_zero,
    output logic                 illegal_op
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t           state;
    logic [SHW-1:0]   count;
    logic             neg;      // operand signs differ: negate the magnitude result
    logic             dz;       // divisor was zero at accept
    // Shared iteration registers.
    // MUL: ma = multiplicand (shifts left), mb = multiplier (shifts right), acc = partial product.
    // DIV: ma = dividend shifting out / quotient shifting in, mb = divisor, acc = partial remainder.
    logic [WIDTH-1:0] ma, mb, acc;

    logic [WIDTH-1:0] rs_mag, rt_mag;
    logic [WIDTH-1:0] sx, zx;
    logic [WIDTH-1:0] single_res;
    logic             single_ill;
    logic [WIDTH-1:0] mul_acc_nx;
    logic [WIDTH-1:0] rem_low;
    logic             div_ge;
    logic [WIDTH-1:0] rem_nx, quo_nx;

    always_comb begin
        rs_mag = rs[WIDTH-1] ? -rs : rs;
        rt_mag = rt[WIDTH-1] ? -rt : rt;
        sx     = {{(WIDTH-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};
        zx     = {{(WIDTH-IMM_WIDTH){1'b0}}, imm};

        single_res = '0;
        single_ill = 1'b0;
        case (inst_num)
            6'd8:    single_res = rs + rt;
            6'd9:    single_res = rs + sx;
            6'd10:   single_res = rs - rt;
            6'd11:   single_res = {imm, {(WIDTH-IMM_WIDTH){1'b0}}};
            6'd16:   single_res = rt << shamt;
            6'd17:   single_res = $unsigned($signed(rt) >>> shamt);
            6'd18:   single_res = rt >> shamt;
            6'd20:   single_res = rs & rt;
            6'd21:   single_res = rs & zx;
            6'd22:   single_res = rs | rt;
            6'd23:   single_res = rs | zx;
            6'd24:   single_res = rs ^ rt;
            6'd25:   single_res = rs ^ zx;
            6'd26:   single_res = ~(rs | rt);
            default: single_ill = 1'b1;
        endcase

        mul_acc_nx = mb[0] ? (acc + ma) : acc;

        // Restoring step. The partial remainder is always below the divisor, so if its top bit
        // is set the shifted value exceeds any WIDTH-bit divisor; the difference then fits in
        // WIDTH bits and modular subtraction gives it exactly.
        rem_low = {acc[WIDTH-2:0], ma[WIDTH-1]};
        div_ge  = acc[WIDTH-1] | (rem_low >= mb);
        rem_nx  = div_ge ? (rem_low - mb) : rem_low;
        quo_nx  = {ma[WIDTH-2:0], div_ge};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            count       <= '0;
            neg         <= 1'b0;
            dz          <= 1'b0;
            ma          <= '0;
            mb          <= '0;
            acc         <= '0;
            busy        <= 1'b0;
            completed   <= 1'b0;
            out         <= '0;
            div_by_zero <= 1'b0;
            illegal_op  <= 1'b0;
        end else begin
            completed <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                        illegal_op  <= 1'b0;
                        ma          <= rs_mag;
                        mb          <= rt_mag;
                        acc         <= '0;
                        neg         <= rs[WIDTH-1] ^ rt[WIDTH-1];
                        dz          <= (rt == '0);
                        count       <= SHW'(WIDTH-1);
                        if (inst_num == 6'd13) begin
                            state <= MUL;
                        end else if (inst_num == 6'd12) begin
                            state <= DIV;
                        end else begin
                            state      <= DONE;
                            completed  <= 1'b1;
                            out        <= single_res;
                            illegal_op <= single_ill;
                        end
                    end
                end
                MUL: begin
                    acc   <= mul_acc_nx;
                    ma    <= ma << 1;
                    mb    <= mb >> 1;
                    count <= count - 1'b1;
                    if (count == '0) begin
                        state     <= DONE;
                        completed <= 1'b1;
                        out       <= neg ? -mul_acc_nx : mul_acc_nx;
                    end
                end
                DIV: begin
                    acc   <= rem_nx;
                    ma    <= quo_nx;
                    count <= count - 1'b1;
                    if (count == '0) begin
                        state       <= DONE;
                        completed   <= 1'b1;
                        div_by_zero <= dz;
                        // Sign correction folded into the last quotient bit.
                        out         <= dz ? '1 : (neg ? -quo_nx : quo_nx);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
